// File: rtl/cbm2_sdram.sv
// cbm2_sdram: single-port SDRAM controller for the CBM-II core.
// Byte-wide requests map onto a 16-bit, 4-bank SDRAM at CL2, BL1.
// Accesses use auto-precharge. Every pin and status output is registered.
module cbm2_sdram #(
  parameter int INIT_CYCLES    = 3200,
  parameter int TRFC_CYCLES    = 3,
  parameter int INIT_REFRESHES = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  output logic        init_done,
  input  logic        ce,
  input  logic        we,
  input  logic [24:0] addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        refresh,
  output logic        busy,
  output logic        overrun,
  output logic        sd_cke,
  output logic        sd_cs_n,
  output logic        sd_ras_n,
  output logic        sd_cas_n,
  output logic        sd_we_n,
  output logic [1:0]  sd_ba,
  output logic [12:0] sd_addr,
  output logic [1:0]  sd_dqm,
  output logic [15:0] sd_dq_out,
  output logic        sd_dq_oe,
  input  logic [15:0] sd_dq_in
);

  typedef enum logic [3:0] {
    S_INIT_WAIT, S_INIT_PRE, S_INIT_REF, S_INIT_MRS,
    S_IDLE, S_ROW, S_COL, S_RD_WAIT, S_RECOVER, S_REF
  } state_t;

  // Command encoding is {cs_n, ras_n, cas_n, we_n}.
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  localparam logic [15:0] INIT_CNT = 16'(INIT_CYCLES);
  localparam logic [15:0] TRFC_M1  = 16'(TRFC_CYCLES - 1);
  localparam logic [7:0]  INIT_REF_N = 8'(INIT_REFRESHES);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  ref_cnt_q, ref_cnt_d;
  logic [24:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [7:0]  din_q, din_d;
  logic        ref_pend_q, ref_pend_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [1:0]  ba_q, ba_d;
  logic [12:0] sd_addr_q, sd_addr_d;
  logic [1:0]  dqm_q, dqm_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic        dq_oe_q, dq_oe_d;
  logic [7:0]  dout_q, dout_d;
  logic        init_done_q, init_done_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;
  logic        cke_q, cke_d;
  logic        start_ref;

  // Next-state and next-output logic for the whole controller.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned, which would infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    ref_cnt_d   = ref_cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    din_d       = din_q;
    ref_pend_d  = ref_pend_q | (refresh & init_done_q);
    cmd_d       = CMD_NOP;
    ba_d        = ba_q;
    sd_addr_d   = sd_addr_q;
    dqm_d       = 2'b11;
    dq_out_d    = dq_out_q;
    dq_oe_d     = 1'b0;
    dout_d      = dout_q;
    init_done_d = init_done_q;
    overrun_d   = overrun_q | (ce & init_done_q & (state_q != S_IDLE));
    cke_d       = 1'b1;
    start_ref   = 1'b0;

    case (state_q)
      S_INIT_WAIT: begin
        if (cnt_q == INIT_CNT) begin
          cmd_d     = CMD_PRE;
          sd_addr_d = 13'h0400;
          state_d   = S_INIT_PRE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_INIT_PRE: begin
        cnt_d     = 16'd0;
        ref_cnt_d = 8'd0;
        state_d   = S_INIT_REF;
      end
      S_INIT_REF: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (ref_cnt_q == INIT_REF_N) begin
          cmd_d     = CMD_MRS;
          ba_d      = 2'b00;
          sd_addr_d = 13'h0020;
          cnt_d     = 16'd1;
          state_d   = S_INIT_MRS;
        end else begin
          cmd_d     = CMD_REF;
          ref_cnt_d = ref_cnt_q + 8'd1;
          cnt_d     = TRFC_M1;
        end
      end
      S_INIT_MRS: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          init_done_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_IDLE: begin
        if (ref_pend_q) begin
          // The pending refresh goes first; a ce in this cycle cannot be held.
          start_ref = 1'b1;
          overrun_d = overrun_q | ce;
        end else if (ce) begin
          cmd_d     = CMD_ACT;
          ba_d      = addr[24:23];
          sd_addr_d = addr[22:10];
          addr_d    = addr;
          we_d      = we;
          din_d     = din;
          state_d   = S_ROW;
        end else if (refresh) begin
          start_ref = 1'b1;
        end
      end
      S_ROW: begin
        cmd_d     = we_q ? CMD_WR : CMD_RD;
        ba_d      = addr_q[24:23];
        sd_addr_d = {3'b001, 1'b0, addr_q[9:1]};
        dqm_d     = addr_q[0] ? 2'b01 : 2'b10;
        if (we_q) begin
          dq_out_d = {din_q, din_q};
          dq_oe_d  = 1'b1;
        end
        state_d = S_COL;
      end
      S_COL: begin
        state_d = we_q ? S_RECOVER : S_RD_WAIT;
      end
      S_RD_WAIT: begin
        dout_d    = addr_q[0] ? sd_dq_in[15:8] : sd_dq_in[7:0];
        state_d   = S_IDLE;
        start_ref = ref_pend_q | refresh;
      end
      S_RECOVER: begin
        state_d   = S_IDLE;
        start_ref = ref_pend_q | refresh;
      end
      S_REF: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          state_d   = S_IDLE;
          start_ref = ref_pend_q | refresh;
        end
      end
      default: state_d = S_INIT_WAIT;
    endcase

    if (start_ref) begin
      cmd_d      = CMD_REF;
      cnt_d      = TRFC_M1;
      ref_pend_d = 1'b0;
      state_d    = S_REF;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset aborts any operation and restarts init.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q     <= S_INIT_WAIT;
      cnt_q       <= '0;
      ref_cnt_q   <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      din_q       <= '0;
      ref_pend_q  <= 1'b0;
      cmd_q       <= CMD_NOP;
      ba_q        <= '0;
      sd_addr_q   <= '0;
      dqm_q       <= 2'b11;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      dout_q      <= 8'h00;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
      overrun_q   <= 1'b0;
      cke_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ref_cnt_q   <= ref_cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      din_q       <= din_d;
      ref_pend_q  <= ref_pend_d;
      cmd_q       <= cmd_d;
      ba_q        <= ba_d;
      sd_addr_q   <= sd_addr_d;
      dqm_q       <= dqm_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      dout_q      <= dout_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      cke_q       <= cke_d;
    end
  end

  assign {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} = cmd_q;
  assign sd_cke    = cke_q;
  assign sd_ba     = ba_q;
  assign sd_addr   = sd_addr_q;
  assign sd_dqm    = dqm_q;
  assign sd_dq_out = dq_out_q;
  assign sd_dq_oe  = dq_oe_q;
  assign dout      = dout_q;
  assign init_done = init_done_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_cbm2_sdram.sv
// tb_cbm2_sdram: directed stimulus with a command scoreboard.
// Stimulus pushes the expected SDRAM commands (with their cycle) into a queue.
// A monitor pops and compares on every non-NOP command seen on the pins.
module tb_cbm2_sdram;

  localparam int INIT_CYCLES    = 3200;
  localparam int TRFC_CYCLES    = 3;
  localparam int INIT_REFRESHES = 2;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        init_done;
  logic        ce;
  logic        we;
  logic [24:0] addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        refresh;
  logic        busy;
  logic        overrun;
  logic        sd_cke;
  logic        sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n;
  logic [1:0]  sd_ba;
  logic [12:0] sd_addr;
  logic [1:0]  sd_dqm;
  logic [15:0] sd_dq_out;
  logic        sd_dq_oe;
  logic [15:0] sd_dq_in;
  logic [3:0]  bus_cmd;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int          cyc;
    logic [3:0]  cmd;
    logic        chk_addr;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [1:0]  dqm;
    logic        oe;
    logic [15:0] dq;
  } exp_t;

  exp_t sb[$];

  cbm2_sdram #(
    .INIT_CYCLES(INIT_CYCLES),
    .TRFC_CYCLES(TRFC_CYCLES),
    .INIT_REFRESHES(INIT_REFRESHES)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .init_done(init_done),
    .ce(ce), .we(we), .addr(addr), .din(din), .dout(dout),
    .refresh(refresh), .busy(busy), .overrun(overrun),
    .sd_cke(sd_cke), .sd_cs_n(sd_cs_n), .sd_ras_n(sd_ras_n),
    .sd_cas_n(sd_cas_n), .sd_we_n(sd_we_n), .sd_ba(sd_ba),
    .sd_addr(sd_addr), .sd_dqm(sd_dqm), .sd_dq_out(sd_dq_out),
    .sd_dq_oe(sd_dq_oe), .sd_dq_in(sd_dq_in)
  );

  assign bus_cmd = {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n};

  always #5 clk_sys = ~clk_sys;

  // Edge counter: at a negedge, cyc equals the number of rising edges so far.
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [3:0] cmd, input logic chk_addr,
                      input logic [1:0] ba, input logic [12:0] a, input logic [1:0] dqm,
                      input logic oe, input logic [15:0] dq);
    exp_t e;
    e.cyc = c; e.cmd = cmd; e.chk_addr = chk_addr; e.ba = ba; e.addr = a;
    e.dqm = dqm; e.oe = oe; e.dq = dq;
    sb.push_back(e);
  endtask

  // Monitor: every non-NOP command must match the oldest expectation.
  always @(negedge clk_sys) begin
    exp_t e;
    if (bus_cmd != CMD_NOP) begin
      if (sb.size() == 0) begin
        check("unexpected_cmd", bus_cmd, CMD_NOP);
      end else begin
        e = sb.pop_front();
        check("cmd", bus_cmd, e.cmd);
        check("cmd_cycle", cyc, e.cyc);
        if (e.chk_addr) begin
          check("cmd_ba", sd_ba, e.ba);
          check("cmd_addr", sd_addr, e.addr);
        end
        check("cmd_dqm", sd_dqm, e.dqm);
        check("cmd_dq_oe", sd_dq_oe, e.oe);
        if (e.oe) check("cmd_dq_out", sd_dq_out, e.dq);
      end
    end
  end

  // Releases reset at the current negedge and checks the whole init sequence.
  task automatic do_init();
    int c;
    int k;
    int m;
    c = cyc;
    reset = 1'b0;
    m = c + 3 + INIT_CYCLES + 2 * TRFC_CYCLES;
    push(c + 1 + INIT_CYCLES, CMD_PRE, 1'b1, 2'b00, 13'h0400, 2'b11, 1'b0, 16'h0);
    push(c + 3 + INIT_CYCLES, CMD_REF, 1'b0, 2'b00, 13'h0, 2'b11, 1'b0, 16'h0);
    push(c + 3 + INIT_CYCLES + TRFC_CYCLES, CMD_REF, 1'b0, 2'b00, 13'h0, 2'b11, 1'b0, 16'h0);
    push(m, CMD_MRS, 1'b1, 2'b00, 13'h0020, 2'b11, 1'b0, 16'h0);
    @(negedge clk_sys);
    check("cke_rise", sd_cke, 1'b1);
    // Requests during init must be ignored without flagging overrun.
    repeat (4) @(negedge clk_sys);
    ce = 1'b1; we = 1'b1; refresh = 1'b1;
    @(negedge clk_sys);
    ce = 1'b0; refresh = 1'b0;
    k = 0;
    while (!init_done && k < 6000) begin
      @(negedge clk_sys);
      k++;
    end
    check("init_done", init_done, 1'b1);
    check("init_done_cycle", cyc, m + 2);
    check("init_busy_low", busy, 1'b0);
    check("init_no_overrun", overrun, 1'b0);
  endtask

  // Issues one request at the current negedge; returns the negedge count.
  task automatic issue(input logic w, input logic [24:0] a, input logic [7:0] d,
                       input logic r, input logic [1:0] e_ba, input logic [12:0] e_row,
                       input logic [12:0] e_col, input logic [1:0] e_dqm,
                       input logic [15:0] e_dq, output int c);
    c = cyc;
    ce = 1'b1; we = w; addr = a; din = d; refresh = r;
    push(c + 1, CMD_ACT, 1'b1, e_ba, e_row, 2'b11, 1'b0, 16'h0);
    push(c + 2, w ? CMD_WR : CMD_RD, 1'b1, e_ba, e_col, e_dqm, w, e_dq);
    @(negedge clk_sys);
    ce = 1'b0; refresh = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset = 1'b1; ce = 1'b0; we = 1'b0; addr = '0; din = '0; refresh = 1'b0;
    sd_dq_in = 16'hFFFF;
    repeat (3) @(negedge clk_sys);

    check("rst_cke", sd_cke, 1'b0);
    check("rst_cmd", bus_cmd, CMD_NOP);
    check("rst_busy", busy, 1'b1);
    check("rst_init_done", init_done, 1'b0);
    check("rst_dout", dout, 8'h00);
    check("rst_overrun", overrun, 1'b0);
    check("rst_dqm", sd_dqm, 2'b11);
    check("rst_dq_oe", sd_dq_oe, 1'b0);
    check("rst_sd_addr", sd_addr, 13'h0);

    do_init();

    // Write 5A to 1AB_CDEF: bank 3, row 0AF3, col 0F7, high byte.
    @(negedge clk_sys);
    issue(1'b1, 25'h1AB_CDEF, 8'h5A, 1'b0, 2'b11, 13'h0AF3, 13'h04F7, 2'b01, 16'h5A5A, c);
    check("wr_busy_e0", busy, 1'b1);
    @(negedge clk_sys);
    @(negedge clk_sys);
    check("wr_oe_one_cycle", sd_dq_oe, 1'b0);
    check("wr_dout_hold", dout, 8'h00);
    @(negedge clk_sys);
    check("wr_busy_e3", busy, 1'b0);

    // Read back the same address at E4 of the write.
    issue(1'b0, 25'h1AB_CDEF, 8'h00, 1'b0, 2'b11, 13'h0AF3, 13'h04F7, 2'b01, 16'h0, c);
    @(negedge clk_sys);
    @(negedge clk_sys);
    check("rd_dout_before_e3", dout, 8'h00);
    sd_dq_in = 16'h5A00;
    @(negedge clk_sys);
    sd_dq_in = 16'hFFFF;
    check("rd_dout_hi", dout, 8'h5A);
    check("rd_busy_e3", busy, 1'b0);

    // Back-to-back read at E4, low byte: bank 0, row 0, col 123.
    issue(1'b0, 25'h000_0246, 8'h00, 1'b0, 2'b00, 13'h0000, 13'h0523, 2'b10, 16'h0, c);
    check("b2b_no_overrun", overrun, 1'b0);
    @(negedge clk_sys);
    @(negedge clk_sys);
    sd_dq_in = 16'h00C3;
    @(negedge clk_sys);
    sd_dq_in = 16'hFFFF;
    check("rd_dout_lo", dout, 8'hC3);
    check("b2b_overrun_clear", overrun, 1'b0);

    // ce at E2 of an active write is dropped and sets overrun.
    @(negedge clk_sys);
    issue(1'b1, 25'h080_0401, 8'h3C, 1'b0, 2'b01, 13'h0001, 13'h0400, 2'b01, 16'h3C3C, c);
    @(negedge clk_sys);
    ce = 1'b1; we = 1'b0; addr = 25'h1FF_FFFF;
    @(negedge clk_sys);
    ce = 1'b0;
    check("overrun_set", overrun, 1'b1);
    repeat (4) @(negedge clk_sys);
    check("overrun_sticky", overrun, 1'b1);
    check("overrun_idle", busy, 1'b0);

    // Refresh, then one pending refresh; a third pulse is dropped.
    c = cyc;
    refresh = 1'b1;
    push(c + 1, CMD_REF, 1'b0, 2'b00, 13'h0, 2'b11, 1'b0, 16'h0);
    push(c + 4, CMD_REF, 1'b0, 2'b00, 13'h0, 2'b11, 1'b0, 16'h0);
    @(negedge clk_sys);
    check("ref_busy", busy, 1'b1);
    @(negedge clk_sys);
    @(negedge clk_sys);
    refresh = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("ref_chain_busy", busy, 1'b1);
    @(negedge clk_sys);
    check("ref_chain_done", busy, 1'b0);

    // ce and refresh together: access first, refresh right after.
    issue(1'b0, 25'h000_0002, 8'h00, 1'b1, 2'b00, 13'h0000, 13'h0401, 2'b10, 16'h0, c);
    push(c + 4, CMD_REF, 1'b0, 2'b00, 13'h0, 2'b11, 1'b0, 16'h0);
    @(negedge clk_sys);
    @(negedge clk_sys);
    sd_dq_in = 16'h1234;
    @(negedge clk_sys);
    sd_dq_in = 16'hFFFF;
    check("ce_ref_dout", dout, 8'h34);
    check("ce_ref_busy_e3", busy, 1'b1);
    @(negedge clk_sys);
    @(negedge clk_sys);
    check("ce_ref_busy_trfc", busy, 1'b1);
    @(negedge clk_sys);
    check("ce_ref_done", busy, 1'b0);

    // Reset in RD_WAIT aborts immediately and restarts init.
    @(negedge clk_sys);
    issue(1'b0, 25'h1AB_CDEF, 8'h00, 1'b0, 2'b11, 13'h0AF3, 13'h04F7, 2'b01, 16'h0, c);
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b1;
    #1;
    check("abort_cke", sd_cke, 1'b0);
    check("abort_cmd", bus_cmd, CMD_NOP);
    check("abort_busy", busy, 1'b1);
    check("abort_dout", dout, 8'h00);
    check("abort_overrun", overrun, 1'b0);
    check("abort_init_done", init_done, 1'b0);
    @(negedge clk_sys);
    do_init();

    repeat (5) @(negedge clk_sys);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
